// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM,
// press/release/long-press strobes and wrapping press counter.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int LONG_CYCLES     = 27000000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1,
   parameter int COUNT_W         = 4
) (
   input  logic               sysclk,
   input  logic               rst_n,
   input  logic               btn,
   output logic               btn_level,
   output logic               press,
   output logic               rel,
   output logic               long_press,
   output logic [COUNT_W-1:0] press_count
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES);
   localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HLAST = HW'(LONG_CYCLES - 1);
   localparam logic IDLE_LVL = BTN_ACTIVE_LOW;

   typedef enum logic [2:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      LONG_HELD,
      RELEASE_WAIT
   } state_t;

   logic          s1;
   logic          s2;
   logic          p;
   state_t        state;
   logic [DW-1:0] dcnt;
   logic [HW-1:0] hcnt;
   logic          ret_long;

   // two-flop synchroniser, parked at the released pad level
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= IDLE_LVL;
         s2 <= IDLE_LVL;
      end else begin
         s1 <= btn;
         s2 <= s1;
      end
   end

   assign p = s2 ^ IDLE_LVL;

   // debounce/hold FSM with registered level, strobes and counter
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RELEASED;
         dcnt        <= '0;
         hcnt        <= '0;
         ret_long    <= 1'b0;
         btn_level   <= 1'b0;
         press       <= 1'b0;
         rel         <= 1'b0;
         long_press  <= 1'b0;
         press_count <= '0;
      end else begin
         press      <= 1'b0;
         rel        <= 1'b0;
         long_press <= 1'b0;
         unique case (state)
            RELEASED: begin
               if (p) begin
                  state <= PRESS_WAIT;
                  dcnt  <= DW'(1);
               end
            end
            PRESS_WAIT: begin
               if (!p) begin
                  state <= RELEASED;
                  dcnt  <= '0;
               end else if (dcnt == DLAST) begin
                  state       <= PRESSED;
                  dcnt        <= '0;
                  hcnt        <= '0;
                  press       <= 1'b1;
                  btn_level   <= 1'b1;
                  press_count <= press_count + 1'b1;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            PRESSED: begin
               if (hcnt == HLAST) begin
                  state      <= LONG_HELD;
                  long_press <= 1'b1;
               end else begin
                  hcnt <= hcnt + 1'b1;
                  if (!p) begin
                     state    <= RELEASE_WAIT;
                     dcnt     <= DW'(1);
                     ret_long <= 1'b0;
                  end
               end
            end
            LONG_HELD: begin
               if (!p) begin
                  state    <= RELEASE_WAIT;
                  dcnt     <= DW'(1);
                  ret_long <= 1'b1;
               end
            end
            RELEASE_WAIT: begin
               // a bounce back returns without touching hcnt
               if (p) begin
                  state <= ret_long ? LONG_HELD : PRESSED;
                  dcnt  <= '0;
               end else if (dcnt == DLAST) begin
                  state     <= RELEASED;
                  dcnt      <= '0;
                  rel       <= 1'b1;
                  btn_level <= 1'b0;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            default: begin
               state <= RELEASED;
               dcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus pushes
// expected strobes, a negedge monitor pops and compares.
module tb_btn_conditioner;

   logic       sysclk;
   logic       rst_n;
   logic       btn;
   logic       btn_level;
   logic       press;
   logic       rel;
   logic       long_press;
   logic [3:0] press_count;

   typedef struct {
      int kind;
      int cyc;
      int cnt;
   } ev_t;

   ev_t exp_q[$];
   int  cyc;
   int  checks;
   int  errors;
   int  model_cnt;
   int  n_press;
   int  n_rel;

   btn_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES(20),
      .BTN_ACTIVE_LOW(1'b1),
      .COUNT_W(4)
   ) dut (
      .sysclk(sysclk),
      .rst_n(rst_n),
      .btn(btn),
      .btn_level(btn_level),
      .press(press),
      .rel(rel),
      .long_press(long_press),
      .press_count(press_count)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   initial cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic push(input int k, input int c, input int n);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.cnt  = n;
      exp_q.push_back(e);
   endtask

   // raw pin changes at a negedge; strobe lands 6 edges later
   task automatic press_clean(input int hold);
      model_cnt = (model_cnt + 1) % 16;
      push(0, cyc + 6, model_cnt);
      btn = 1'b0;
      tick(hold);
   endtask

   task automatic release_clean(input int hold);
      push(1, cyc + 6, model_cnt);
      btn = 1'b1;
      tick(hold);
   endtask

   // monitor: every strobe must match the head of the queue
   always @(negedge sysclk) begin : monitor
      ev_t e;
      int  kind;
      int  k;
      if (press) n_press++;
      if (rel) n_rel++;
      if (press || rel || long_press) begin
         k = int'(press) + int'(rel) + int'(long_press);
         kind = press ? 0 : (rel ? 1 : 2);
         chk("strobe_single", k, 1);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe kind %0d at cycle %0d",
                     kind, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_kind", kind, e.kind);
            chk("strobe_cycle", cyc, e.cyc);
            chk("strobe_count", int'(press_count), e.cnt);
            chk("strobe_level", int'(btn_level), int'(e.kind != 1));
         end
      end
   end

   initial begin
      int c0;
      int r;
      checks    = 0;
      errors    = 0;
      model_cnt = 0;
      n_press   = 0;
      n_rel     = 0;
      btn       = 1'b1;
      rst_n     = 1'b0;
      tick(3);
      chk("rst_level", int'(btn_level), 0);
      chk("rst_press", int'(press), 0);
      chk("rst_release", int'(rel), 0);
      chk("rst_long", int'(long_press), 0);
      chk("rst_count", int'(press_count), 0);
      rst_n = 1'b1;
      tick(3);

      // clean press and release
      c0 = cyc;
      model_cnt = 1;
      push(0, c0 + 6, 1);
      btn = 1'b0;
      tick(5);
      chk("clean_level_pre", int'(btn_level), 0);
      tick(1);
      chk("clean_level_post", int'(btn_level), 1);
      chk("clean_count", int'(press_count), 1);
      tick(4);
      release_clean(10);

      // press bounce: 3 samples, 1 glitch, then stable
      c0 = cyc;
      model_cnt = 2;
      push(0, c0 + 10, 2);
      btn = 1'b0;
      tick(3);
      btn = 1'b1;
      tick(1);
      btn = 1'b0;
      tick(5);
      chk("bounce_level", int'(btn_level), 0);
      tick(5);
      release_clean(10);

      // long hold
      c0 = cyc;
      model_cnt = 3;
      push(0, c0 + 6, 3);
      push(2, c0 + 26, 3);
      btn = 1'b0;
      tick(46);
      release_clean(10);

      // release bounce: 2 released, 1 pressed, then released
      c0 = cyc;
      model_cnt = 4;
      push(0, c0 + 6, 4);
      btn = 1'b0;
      tick(10);
      r = cyc;
      push(1, r + 9, 4);
      btn = 1'b1;
      tick(2);
      btn = 1'b0;
      tick(1);
      btn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("relbounce_level", int'(btn_level), 1);
      end
      tick(6);

      // one-sample release glitch delays long_press by one cycle
      c0 = cyc;
      model_cnt = 5;
      push(0, c0 + 6, 5);
      push(2, c0 + 27, 5);
      btn = 1'b0;
      tick(10);
      btn = 1'b1;
      tick(1);
      btn = 1'b0;
      tick(30);
      release_clean(10);

      // reset during press qualification
      btn = 1'b0;
      tick(4);
      rst_n = 1'b0;
      #1;
      chk("midrst_level", int'(btn_level), 0);
      chk("midrst_press", int'(press), 0);
      chk("midrst_release", int'(rel), 0);
      chk("midrst_long", int'(long_press), 0);
      chk("midrst_count", int'(press_count), 0);
      tick(2);
      model_cnt = 1;
      push(0, cyc + 6, 1);
      rst_n = 1'b1;
      tick(10);
      release_clean(10);

      // counter wrap over 17 presses
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(2);
      model_cnt = 0;
      n_press = 0;
      n_rel = 0;
      for (int i = 1; i <= 17; i++) begin
         press_clean(8);
         if (i == 15) chk("wrap_15", int'(press_count), 15);
         if (i == 16) chk("wrap_16", int'(press_count), 0);
         if (i == 17) chk("wrap_17", int'(press_count), 1);
         release_clean(8);
      end
      tick(5);
      chk("wrap_press_total", n_press, 17);
      chk("wrap_release_total", n_rel, 17);
      chk("pending_strobes", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Conditions the raw board push-button for the LED display path. It synchronises the raw pin and debounces it, then emits single-cycle press, release and long-press strobes. It also keeps a wrapping press counter that the downstream LED/shift-register stage consumes directly. The block sits between the `btn` pad and the LED logic, all in the `sysclk` domain.

## Interface
- `DEBOUNCE_CYCLES`, 270000, consecutive stable synchronised samples required to accept a level change (10 ms at 27 MHz); legal range ≥ 2.
- `LONG_CYCLES`, 27000000, cycles held after the accepted press before `long_press` fires (1 s at 27 MHz); must exceed `DEBOUNCE_CYCLES`.
- `BTN_ACTIVE_LOW`, 1, 1 means raw `btn`=0 is pressed; 0 means raw `btn`=1 is pressed.
- `COUNT_W`, 4, width of `press_count`.
- `sysclk`  in  1  sole clock; all flops are rising-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
- `btn`  in  1  raw, asynchronous, bouncing button pin.
- `btn_level`  out  1  debounced level, 1 = pressed.
- `press`  out  1  one-cycle strobe on an accepted press.
- `release`  out  1  one-cycle strobe on an accepted release.
- `long_press`  out  1  one-cycle strobe, at most once per press.
- `press_count`  out  `COUNT_W`  accepted presses, modulo 2^`COUNT_W`.

## Operation
- Input synchroniser:
  - Two flops, `btn` → s1 → s2.
  - Both reset to the released raw level (`BTN_ACTIVE_LOW` ? 1 : 0).
  - `p` = s2 normalised to 1 = pressed.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT.
- Debounce counter `dcnt` is wide enough for `DEBOUNCE_CYCLES`. Hold counter `hcnt` is wide enough for `LONG_CYCLES`.
- RELEASED:
  - `p`=1 → PRESS_WAIT, `dcnt`=1.
- PRESS_WAIT:
  - `p`=0 → RELEASED, `dcnt`=0. Any bounce restarts the qualification.
  - `p`=1 and `dcnt`=`DEBOUNCE_CYCLES`-1 → PRESSED. `press`=1, `btn_level`=1, `press_count`+1, `hcnt`=0.
  - Otherwise `dcnt`+1.
- PRESSED:
  - `hcnt` increments each cycle while in PRESSED.
  - `hcnt`=`LONG_CYCLES`-1 → LONG_HELD, `long_press`=1.
  - `p`=0 → RELEASE_WAIT, `dcnt`=1, return target = PRESSED.
- LONG_HELD:
  - `p`=0 → RELEASE_WAIT, `dcnt`=1, return target = LONG_HELD.
  - No further `long_press` while in this state.
- RELEASE_WAIT:
  - `p`=1 → return target state, `dcnt`=0. `hcnt` holds its value and is not cleared.
  - `p`=0 and `dcnt`=`DEBOUNCE_CYCLES`-1 → RELEASED. `release`=1, `btn_level`=0.
  - Otherwise `dcnt`+1.
- `press_count`:
  - Wraps (2^`COUNT_W`-1) → 0.
  - Never changes except on a `press` cycle.
- Strobes are registered outputs and are never high for two consecutive cycles. `press` and `release` are never high in the same cycle.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State RELEASED, `dcnt`=`hcnt`=0.
  - `btn_level`=`press`=`release`=`long_press`=0, `press_count`=0.
  - Synchroniser at the released level.
- Leaving reset: if `btn` is held pressed through reset deassert, it is treated as a fresh press. `press` fires after full qualification, as below.
- Latency: let edge 0 be the first `sysclk` edge that samples a new, thereafter stable `btn` level.
  - s2 updates at edge 1; the FSM takes its first sample at edge 2.
  - `press`/`release`/`btn_level` update at edge `DEBOUNCE_CYCLES`+1.
- `long_press` rises at the edge `LONG_CYCLES` cycles after the `press` edge, counting only cycles spent in PRESSED.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles never change `btn_level` and produce no strobe.
- Reset asserted mid-qualification or mid-hold: every output clears immediately. No pending strobe is emitted after reset releases.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `BTN_ACTIVE_LOW`=1.
- Clean press: `btn` 1→0 first sampled at edge 0, then held.
  - `press`=1 only in the cycle after edge 5.
  - `btn_level`=1 from edge 5.
  - `press_count` 0→1.
- Bounce: `btn`=0 for 3 synchronised samples, 1 for 1, then 0 stable.
  - No strobe during the bounce.
  - `press` fires 4 stable samples after the final 0, exactly once.
- Long hold: clean press, then hold for 40 cycles.
  - `long_press` pulses once, 20 cycles after the `press` edge.
  - Release yields one `release`; there is no second `long_press`.
- Release bounce: from PRESSED, `btn`=1 for 2 samples, 0 for 1, then 1 stable.
  - `btn_level` stays 1 through the bounce.
  - `release` fires 4 samples after the final 1; `hcnt` is preserved across the bounce.
- Wrap: 17 clean press/release pairs.
  - `press_count` reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
  - 17 `press` and 17 `release` strobes in total.
- Reset: assert `rst_n`=0 during PRESS_WAIT while `btn`=0; release it with `btn` still 0.
  - All outputs read 0 immediately.
  - `press` fires at edge 5 counted from the first edge after deassert.
